// File: rtl/ysyx_25060170_mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids, boot PC
// and the timeout counter width helper.
package ysyx_25060170_mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  // Width that holds 0..t without wrapping; stays 1 bit when the timeout is disabled.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/ysyx_25060170_mem_arb_if.sv
// Bundle of the IFU, LSU and memory handshakes; the arbiter takes the slave view,
// the surrounding core / memory model takes the master view.
interface ysyx_25060170_mem_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                ifu_req_valid;
  logic                ifu_req_ready;
  logic [ADDR_W-1:0]   ifu_addr;
  logic                ifu_resp_valid;
  logic [DATA_W-1:0]   ifu_rdata;
  logic                ifu_resp_err;

  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_resp_valid;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                lsu_resp_err;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_25060170_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the master that did not win last time is granted.
// Zero latency; grants are one-hot or all-zero.
module ysyx_25060170_rr_arb2
  import ysyx_25060170_mem_arb_pkg::*;
(
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic last_grant,
  output logic gnt_ifu,
  output logic gnt_lsu
);

  always_comb begin
    gnt_ifu = req_ifu & (~req_lsu | (last_grant == OWN_LSU));
    gnt_lsu = req_lsu & ~gnt_ifu;
  end

endmodule

// File: rtl/ysyx_25060170_mem_arb.sv
// Single-outstanding round-robin arbiter sharing one memory port between IFU and LSU.
// Min 3 cycles/transaction; grant held from accept until response or timeout, req_ready only in IDLE.
module ysyx_25060170_mem_arb
  import ysyx_25060170_mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_25060170_mem_arb_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam bit          TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]          state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic gnt_ifu, gnt_lsu;
  logic ifu_rdy, lsu_rdy;
  logic to_fire;

  ysyx_25060170_rr_arb2 u_rr (
    .req_ifu    (bus.ifu_req_valid),
    .req_lsu    (bus.lsu_req_valid),
    .last_grant (last_q),
    .gnt_ifu    (gnt_ifu),
    .gnt_lsu    (gnt_lsu)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    ifu_rdy = 1'b0;
    lsu_rdy = 1'b0;
    to_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Readiness is masked by reset so every output reads 0 while it is held.
        ifu_rdy = gnt_ifu & ~rst;
        lsu_rdy = gnt_lsu & ~rst;
        if (gnt_ifu) begin
          addr_d  = bus.ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          owner_d = OWN_IFU;
          last_d  = OWN_IFU;
          state_d = ST_REQ;
        end else if (gnt_lsu) begin
          addr_d  = bus.lsu_addr;
          wen_d   = bus.lsu_wen;
          wdata_d = bus.lsu_wdata;
          wmask_d = bus.lsu_wmask;
          owner_d = OWN_LSU;
          last_d  = OWN_LSU;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end
      end
      ST_RESP: begin
        // A real response on the last allowed cycle beats the synthesised error.
        if (bus.mem_resp_valid) begin
          state_d = ST_IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          to_fire = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
    end
  end

  logic              in_resp;
  logic              resp_fire;
  logic [DATA_W-1:0] rdata_out;

  assign in_resp   = (state_q == ST_RESP);
  assign resp_fire = in_resp & (bus.mem_resp_valid | to_fire);
  assign rdata_out = to_fire ? '0 : bus.mem_rdata;

  assign bus.ifu_req_ready  = ifu_rdy;
  assign bus.lsu_req_ready  = lsu_rdy;

  assign bus.ifu_resp_valid = resp_fire & (owner_q == OWN_IFU);
  assign bus.ifu_resp_err   = to_fire & (owner_q == OWN_IFU);
  assign bus.ifu_rdata      = (in_resp && (owner_q == OWN_IFU)) ? rdata_out : '0;

  assign bus.lsu_resp_valid = resp_fire & (owner_q == OWN_LSU);
  assign bus.lsu_resp_err   = to_fire & (owner_q == OWN_LSU);
  assign bus.lsu_rdata      = (in_resp && (owner_q == OWN_LSU)) ? rdata_out : '0;

  assign bus.mem_req_valid  = (state_q == ST_REQ);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

endmodule

// File: tb/tb_ysyx_25060170_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter with a response scoreboard.
module tb_ysyx_25060170_mem_arb;
  import ysyx_25060170_mem_arb_pkg::*;

  localparam int TO = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic        who;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  ysyx_25060170_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_25060170_mem_arb #(.TIMEOUT_CYCLES(TO), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [139:0] outs;
  assign outs = {bus.ifu_req_ready, bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_resp_err,
                 bus.lsu_req_ready, bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_resp_err,
                 bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    checks++;
    assert (outs === '0) else begin
      errors++;
      $error("FAIL %s observed=%h expected=0", tag, outs);
    end
  endtask

  // Response monitor: every pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL stray_resp observed ifu=%0b lsu=%0b expected no response",
               bus.ifu_resp_valid, bus.lsu_resp_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_owner", {bus.ifu_resp_valid, bus.lsu_resp_valid}, e.who ? 2'b01 : 2'b10);
        chk("resp_rdata", e.who ? bus.lsu_rdata : bus.ifu_rdata, e.rdata);
        chk("resp_err", e.who ? bus.lsu_resp_err : bus.ifu_resp_err, e.err);
        chk("nonowner_rdata", e.who ? bus.ifu_rdata : bus.lsu_rdata, 0);
      end
    end
  end

  // Entered at #1 after a rising edge with the DUT in IDLE and the winner's request driven.
  // rdelay < 0 means the memory never answers and a timeout error is expected.
  task automatic serve(input logic who, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] wm,
                       input int stall, input int rdelay, input logic [31:0] rd);
    @(negedge clk);
    chk("ifu_req_ready", bus.ifu_req_ready, who == OWN_IFU);
    chk("lsu_req_ready", bus.lsu_req_ready, who == OWN_LSU);
    @(posedge clk); #1;
    if (who == OWN_IFU) bus.ifu_req_valid = 1'b0;
    else                bus.lsu_req_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_req_valid", bus.mem_req_valid, 1);
      chk("stall_addr", bus.mem_addr, a);
      chk("stall_wdata", bus.mem_wdata, wd);
      chk("stall_ready_low", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
      @(posedge clk); #1;
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("req_valid", bus.mem_req_valid, 1);
    chk("req_addr", bus.mem_addr, a);
    chk("req_wen", bus.mem_wen, w);
    chk("req_wdata", bus.mem_wdata, wd);
    chk("req_wmask", bus.mem_wmask, wm);
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    if (rdelay < 0) begin
      for (int i = 0; i < TO - 1; i++) begin
        @(negedge clk);
        chk("to_quiet", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        @(posedge clk); #1;
      end
      sb.push_back('{who: who, rdata: 32'h0, err: 1'b1});
      @(negedge clk);
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i < rdelay; i++) begin
        @(negedge clk);
        chk("resp_quiet", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        @(posedge clk); #1;
      end
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = rd;
      sb.push_back('{who: who, rdata: rd, err: 1'b0});
      @(negedge clk);
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = '0;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic drive_ifu(input logic [31:0] a);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = a;
  endtask

  task automatic drive_lsu(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] wm);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = a;
    bus.lsu_wen       = w;
    bus.lsu_wdata     = wd;
    bus.lsu_wmask     = wm;
  endtask

  initial begin
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = RESET_PC;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata     = '0;

    // Reset state, with a request pending and a stray response on the bus.
    bus.mem_resp_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outs_zero("reset_outputs");
    @(posedge clk); #1;
    bus.ifu_req_valid  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    rst = 1'b0;

    // IFU alone.
    drive_ifu(RESET_PC);
    serve(OWN_IFU, RESET_PC, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0000_0413);

    // Fresh reset, then a tie: IFU first, LSU store the cycle after.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_ifu(32'h8000_0004);
    drive_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    serve(OWN_IFU, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0000_0013);
    serve(OWN_LSU, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h0);

    // Second tie goes to IFU again since LSU won last.
    drive_ifu(32'h8000_0008);
    drive_lsu(32'h8000_2000, 1'b0, 32'h0, 4'h0);
    serve(OWN_IFU, 32'h8000_0008, 1'b0, 32'h0, 4'h0, 0, 2, 32'h0010_0093);

    // Tie with IFU last: LSU load under 5 cycles of memory backpressure.
    drive_ifu(32'h8000_000C);
    serve(OWN_LSU, 32'h8000_2000, 1'b0, 32'h0, 4'h0, 5, 0, 32'h1234_5678);
    serve(OWN_IFU, 32'h8000_000C, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0020_0113);

    // Timeout, then a late response that must be ignored.
    drive_lsu(32'h8000_4000, 1'b0, 32'h0, 4'h0);
    serve(OWN_LSU, 32'h8000_4000, 1'b0, 32'h0, 4'h0, 0, -1, 32'h0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0BAD_0BAD;
    repeat (2) begin
      @(negedge clk);
      chk("late_resp_ignored", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid}, 0);
      @(posedge clk); #1;
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;

    // Response landing on the final timeout cycle wins.
    drive_lsu(32'h8000_5000, 1'b0, 32'h0, 4'h0);
    serve(OWN_LSU, 32'h8000_5000, 1'b0, 32'h0, 4'h0, 0, TO - 1, 32'hCAFE_F00D);

    // Reset in the middle of RESP.
    drive_lsu(32'h8000_6000, 1'b1, 32'h5555_AAAA, 4'h3);
    @(negedge clk);
    chk("mid_lsu_ready", bus.lsu_req_ready, 1);
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready  = 1'b0;
    rst = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h7777_7777;
    @(negedge clk);
    chk_outs_zero("reset_mid_resp");
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    rst = 1'b0;
    @(negedge clk);
    chk_outs_zero("after_reset_idle");
    @(posedge clk); #1;
    drive_ifu(RESET_PC);
    drive_lsu(32'h8000_7000, 1'b0, 32'h0, 4'h0);
    serve(OWN_IFU, RESET_PC, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0000_0297);
    serve(OWN_LSU, 32'h8000_7000, 1'b0, 32'h0, 4'h0, 1, 0, 32'hA5A5_5A5A);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
